fp4_mul_pipe: RTL and testbench

FP4_MUL_PIPE -- requirements
Module: fp4_mul_pipe

---
 rtl/fp4_pkg.sv | 67 ++++++
 rtl/fp4_e2m1_mul_lane.sv | 70 +++++++
 rtl/fp4_mul_pipe.sv | 93 +++++++++
 tb/tb_fp4_mul_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp4_pkg.sv
// e2m1 FP4 types, constants and the rounding helper shared by the multiplier lanes.
// Purely combinational helpers; no state, no flow control.
package fp4_pkg;

    typedef struct packed {
        logic       sign;
        logic [1:0] exponent;
        logic       mantissa;
    } fp4_e2m1_t;

    localparam int         BIAS        = 1;
    localparam int         MAX_EXP     = 3;
    localparam logic [2:0] FP4_MAX_MAG = 3'b111;

    // RNE overflow threshold in quarter units: midpoint between 6.0 and 8.0,
    // the first value of the binade above MAX_EXP; the tie goes to 8.0 (even).
    localparam int OVF_RNE_Q = (4 * 6 + 4 * (1 << (MAX_EXP - BIAS + 1))) / 2;

    typedef enum logic {
        RND_RNE = 1'b0,
        RND_RTZ = 1'b1
    } round_mode_e;

    // Magnitude of each 3-bit e2m1 code expressed in units of 0.25.
    function automatic logic [7:0] mag_quarters(input logic [2:0] code);
        case (code)
            3'd0:    return 8'd0;
            3'd1:    return 8'd2;
            3'd2:    return 8'd4;
            3'd3:    return 8'd6;
            3'd4:    return 8'd8;
            3'd5:    return 8'd12;
            3'd6:    return 8'd16;
            default: return 8'd24;
        endcase
    endfunction

    // Rounds an exact magnitude q (units of 0.25) onto the e2m1 grid.
    // Returns {overflow, magnitude_code}; overflowed magnitudes come back as FP4_MAX_MAG.
    function automatic logic [3:0] round_quarters(input logic [7:0] q, input round_mode_e mode);
        logic [2:0] lo;
        logic [2:0] mag;
        logic [7:0] d_lo;
        logic [7:0] d_hi;
        logic       ovf;
        lo = '0;
        for (int c = 1; c < 8; c++) begin
            if (q >= mag_quarters(3'(c))) lo = 3'(c);
        end
        mag  = lo;
        ovf  = 1'b0;
        d_lo = '0;
        d_hi = '0;
        if (mode == RND_RTZ) begin
            ovf = q > mag_quarters(FP4_MAX_MAG);
        end else if (lo == FP4_MAX_MAG) begin
            ovf = q >= 8'(OVF_RNE_Q);
        end else begin
            d_lo = q - mag_quarters(lo);
            d_hi = mag_quarters(lo + 3'd1) - q;
            // Code LSB is the mantissa bit, so an odd lo loses a tie.
            if (d_hi < d_lo || (d_hi == d_lo && lo[0])) mag = lo + 3'd1;
        end
        return {ovf, mag};
    endfunction

endpackage

// File: rtl/fp4_e2m1_mul_lane.sv
// One e2m1 x e2m1 multiplier lane: S1 decodes and forms significand product / exponent sum,
// S2 rounds, packs and compares with golden; 2-cycle latency, each stage loads only when told.
module fp4_e2m1_mul_lane
    import fp4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s1_load,
    input  logic        s2_load,
    input  fp4_e2m1_t   op_a,
    input  fp4_e2m1_t   op_b,
    input  logic [3:0]  golden,
    input  logic        s1_sat_mode,
    input  round_mode_e s1_rnd_mode,
    output logic [3:0]  result,
    output logic        ovf,
    output logic        result_err
);

    // Value in units of 0.5 is sig << scl, with sig = {hidden bit, mantissa}.
    logic [1:0] sig_a, sig_b;
    logic [1:0] scl_a, scl_b;

    assign sig_a = {|op_a.exponent, op_a.mantissa};
    assign sig_b = {|op_b.exponent, op_b.mantissa};
    assign scl_a = (op_a.exponent == 2'd0) ? 2'd0 : op_a.exponent - 2'(BIAS);
    assign scl_b = (op_b.exponent == 2'd0) ? 2'd0 : op_b.exponent - 2'(BIAS);

    logic       s1_sign;
    logic [3:0] s1_sig_prod;
    logic [2:0] s1_exp_sum;
    logic [3:0] s1_golden;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_sign     <= 1'b0;
            s1_sig_prod <= '0;
            s1_exp_sum  <= '0;
            s1_golden   <= '0;
        end else if (s1_load) begin
            s1_sign     <= op_a.sign ^ op_b.sign;
            s1_sig_prod <= 4'(sig_a) * 4'(sig_b);
            s1_exp_sum  <= 3'(scl_a) + 3'(scl_b);
            s1_golden   <= golden;
        end
    end

    logic [7:0] prod_q;
    logic [3:0] rounded;
    logic [3:0] res_n;
    logic       err_n;

    assign prod_q  = 8'(s1_sig_prod) << s1_exp_sum;
    assign rounded = round_quarters(prod_q, s1_rnd_mode);
    assign res_n   = {s1_sign, rounded[2:0]};
    assign err_n   = (res_n != s1_golden) && !((res_n[2:0] == 3'd0) && (s1_golden[2:0] == 3'd0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result     <= '0;
            ovf        <= 1'b0;
            result_err <= 1'b0;
        end else if (s2_load) begin
            result     <= res_n;
            ovf        <= rounded[3] & ~s1_sat_mode;
            result_err <= err_n;
        end
    end

endmodule

// File: rtl/fp4_mul_pipe.sv
// LANES-wide e2m1 multiplier with golden compare and saturating mismatch counter.
// 2-cycle latency; stalls hold S2, in_ready drops only when both stages are full and out_ready is low.
module fp4_mul_pipe
    import fp4_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   operand_a,
    input  logic [4*LANES-1:0]   operand_b,
    input  logic [4*LANES-1:0]   golden_value,
    input  logic                 saturation_mode,
    input  logic                 round_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   result,
    output logic [LANES-1:0]     ovf,
    output logic [LANES-1:0]     result_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    logic        s1_vld, s2_vld;
    logic        s1_sat;
    round_mode_e s1_rnd;
    logic        s2_adv, s1_load, s2_load;

    assign s2_adv    = !s2_vld || out_ready;
    assign in_ready  = !s1_vld || s2_adv;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_vld && s2_adv;
    assign out_valid = s2_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_sat <= 1'b0;
            s1_rnd <= RND_RNE;
        end else begin
            if (in_ready) s1_vld <= in_valid;
            if (s2_adv)   s2_vld <= s1_vld;
            if (s1_load) begin
                s1_sat <= saturation_mode;
                s1_rnd <= round_mode_e'(round_mode);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp4_e2m1_mul_lane u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .s1_load     (s1_load),
            .s2_load     (s2_load),
            .op_a        (fp4_e2m1_t'(operand_a[4*i +: 4])),
            .op_b        (fp4_e2m1_t'(operand_b[4*i +: 4])),
            .golden      (golden_value[4*i +: 4]),
            .s1_sat_mode (s1_sat),
            .s1_rnd_mode (s1_rnd),
            .result      (result[4*i +: 4]),
            .ovf         (ovf[i]),
            .result_err  (result_err[i])
        );
    end

    localparam int CW = ERR_CNT_W + 5;

    logic [4:0]    err_pop;
    logic [CW-1:0] err_sum;

    always_comb begin
        err_pop = '0;
        for (int i = 0; i < LANES; i++) err_pop = err_pop + 5'(result_err[i]);
    end

    assign err_sum = CW'(err_count) + CW'(err_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            err_count <= (|err_sum[CW-1:ERR_CNT_W]) ? '1 : err_sum[ERR_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_fp4_mul_pipe.sv
// Bench for fp4_mul_pipe: real-valued reference model and scoreboard queue, directed
// corner beats, random streaming with random backpressure, and mid-flight reset.
module tb_fp4_mul_pipe;

    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready, in_ready2;
    logic [4*L-1:0] operand_a, operand_b, golden_value;
    logic           saturation_mode, round_mode;
    logic           out_valid, out_valid2;
    logic           out_ready;
    logic [4*L-1:0] result, result2;
    logic [L-1:0]   ovf, ovf2, result_err, result_err2;
    logic [15:0]    err_count;
    logic [1:0]     err_count2;
    logic           err_clr;

    always #5 clk = ~clk;

    fp4_mul_pipe #(.LANES(L), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .golden_value(golden_value),
        .saturation_mode(saturation_mode), .round_mode(round_mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf),
        .result_err(result_err), .err_count(err_count), .err_clr(err_clr)
    );

    fp4_mul_pipe #(.LANES(L), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .operand_a(operand_a), .operand_b(operand_b), .golden_value(golden_value),
        .saturation_mode(saturation_mode), .round_mode(round_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .ovf(ovf2),
        .result_err(result_err2), .err_count(err_count2), .err_clr(err_clr)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real grid_val(input int i);
        case (i)
            0: return 0.0;
            1: return 0.5;
            2: return 1.0;
            3: return 1.5;
            4: return 2.0;
            5: return 3.0;
            6: return 4.0;
            7: return 6.0;
            default: return 8.0;
        endcase
    endfunction

    function automatic real dec(input logic [3:0] v);
        int e, m;
        e = int'(v[2:1]);
        m = int'(v[0]);
        if (e == 0) return 0.5 * m;
        return (1.0 + 0.5 * m) * real'(1 << (e - 1));
    endfunction

    // Returns {ovf_flag, result[3:0]}.
    function automatic logic [4:0] model_mul(input logic [3:0] a, input logic [3:0] b,
                                             input logic sat, input logic rnd);
        real  p, d, bd;
        int   idx;
        logic ov;
        p   = dec(a) * dec(b);
        idx = 0;
        ov  = 1'b0;
        if (rnd) begin
            if (p > 6.0) begin
                idx = 7;
                ov  = 1'b1;
            end else begin
                for (int i = 1; i < 8; i++) if (grid_val(i) <= p) idx = i;
            end
        end else begin
            bd = p;
            for (int i = 1; i < 9; i++) begin
                d = grid_val(i) - p;
                if (d < 0.0) d = -d;
                if (d < bd || (d == bd && (i % 2) == 0)) begin
                    idx = i;
                    bd  = d;
                end
            end
            if (idx == 8) begin
                idx = 7;
                ov  = 1'b1;
            end
        end
        return {ov & ~sat, a[3] ^ b[3], 3'(idx)};
    endfunction

    function automatic bit same_val(input logic [3:0] x, input logic [3:0] y);
        return (x == y) || (x[2:0] == 3'd0 && y[2:0] == 3'd0);
    endfunction

    typedef struct {
        logic [4*L-1:0] res;
        logic [L-1:0]   ovf;
        logic [L-1:0]   err;
    } exp_t;

    function automatic exp_t model_beat(input logic [4*L-1:0] a, input logic [4*L-1:0] b,
                                        input logic [4*L-1:0] g, input logic sat, input logic rnd);
        exp_t       e;
        logic [4:0] r;
        for (int i = 0; i < L; i++) begin
            r               = model_mul(a[4*i +: 4], b[4*i +: 4], sat, rnd);
            e.res[4*i +: 4] = r[3:0];
            e.ovf[i]        = r[4];
            e.err[i]        = !same_val(r[3:0], g[4*i +: 4]);
        end
        return e;
    endfunction

    exp_t q[$];
    int   cnt_m = 0, cnt2_m = 0;
    bit   rst_seen = 0;

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        exp_t e;
        int   pc;
        if (!rst_n) begin
            if (rst_seen) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_result", result, 0);
                check("rst_ovf", ovf, 0);
                check("rst_err", result_err, 0);
                check("rst_err_count", err_count, 0);
                check("rst_out_valid_w2", out_valid2, 0);
                check("rst_err_count_w2", err_count2, 0);
            end
            rst_seen = 1;
            q.delete();
            cnt_m  = 0;
            cnt2_m = 0;
        end else begin
            rst_seen = 0;
            check("err_count", err_count, cnt_m);
            check("err_count_w2", err_count2, cnt2_m);
            check("in_ready", in_ready, out_ready || q.size() < 2);
            check("in_ready_w2", in_ready2, out_ready || q.size() < 2);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    check("result", result, q[0].res);
                    check("ovf", ovf, q[0].ovf);
                    check("result_err", result_err, q[0].err);
                    check("result_w2", result2, q[0].res);
                end
            end
            pc = 0;
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < L; i++) pc += int'(e.err[i]);
            end
            if (err_clr) begin
                cnt_m  = 0;
                cnt2_m = 0;
            end else if (out_valid && out_ready) begin
                cnt_m  = (cnt_m + pc > 65535) ? 65535 : cnt_m + pc;
                cnt2_m = (cnt2_m + pc > 3) ? 3 : cnt2_m + pc;
            end
            if (in_valid && in_ready)
                q.push_back(model_beat(operand_a, operand_b, golden_value, saturation_mode, round_mode));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4*L-1:0] a, input logic [4*L-1:0] b,
                         input logic [4*L-1:0] g, input logic sat, input logic rnd);
        operand_a       = a;
        operand_b       = b;
        golden_value    = g;
        saturation_mode = sat;
        round_mode      = rnd;
        in_valid        = 1'b1;
    endtask

    task automatic drive_random();
        logic [4*L-1:0] a, b, g;
        logic           sat, rnd;
        exp_t           e;
        a   = 16'($urandom);
        b   = 16'($urandom);
        sat = 1'($urandom);
        rnd = 1'($urandom);
        e   = model_beat(a, b, '0, sat, rnd);
        for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    g[4*i +: 4] = e.res[4*i +: 4];
                2:       g[4*i +: 4] = e.res[4*i +: 4] ^ 4'h8;
                default: g[4*i +: 4] = 4'($urandom);
            endcase
        end
        drive(a, b, g, sat, rnd);
    endtask

    // Single beat into an empty pipe; checks 2-cycle latency and lane 0 literally.
    task automatic directed(input string name, input logic [3:0] a0, input logic [3:0] b0,
                            input logic sat, input logic rnd, input logic [3:0] exp0,
                            input logic exp_ovf0);
        logic [4*L-1:0] a, b, g;
        exp_t           e;
        a = {12'($urandom), a0};
        b = {12'($urandom), b0};
        e = model_beat(a, b, '0, sat, rnd);
        g = {e.res[4*L-1:4], exp0};
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(a, b, g, sat, rnd);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1_valid"}, out_valid, 0);
        @(negedge clk);
        check({name, "_lat2_valid"}, out_valid, 1);
        check({name, "_res"}, result[3:0], exp0);
        check({name, "_ovf"}, ovf[0], exp_ovf0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [4*L-1:0] a, b;
        exp_t           e;
        int             sent, cyc;
        bit             acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        operand_a = '0; operand_b = '0; golden_value = '0;
        saturation_mode = 1'b0; round_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the model with hand-computed products.
        check("m_1p5x1p5", model_mul(4'h3, 4'h3, 0, 0), 5'h04);
        check("m_0p75_rne", model_mul(4'h1, 4'h3, 0, 0), 5'h02);
        check("m_0p75_rtz", model_mul(4'h1, 4'h3, 0, 1), 5'h01);
        check("m_negzero", model_mul(4'h1, 4'h9, 0, 0), 5'h08);
        check("m_0p25_rne", model_mul(4'h1, 4'h1, 0, 0), 5'h00);
        check("m_4p5_rne", model_mul(4'h3, 4'h5, 0, 0), 5'h06);
        check("m_4p5_rtz", model_mul(4'h3, 4'h5, 0, 1), 5'h06);
        check("m_9_sat0", model_mul(4'h5, 4'h5, 0, 0), 5'h17);
        check("m_9_sat1", model_mul(4'h5, 4'h5, 1, 0), 5'h07);
        check("m_9_rtz", model_mul(4'h3, 4'h7, 0, 1), 5'h17);
        check("m_neg9", model_mul(4'hD, 4'h5, 0, 0), 5'h1F);

        directed("d_1p5x1p5", 4'h3, 4'h3, 0, 0, 4'h4, 0);
        directed("d_0p75_rne", 4'h1, 4'h3, 0, 0, 4'h2, 0);
        directed("d_0p75_rtz", 4'h1, 4'h3, 0, 1, 4'h1, 0);
        directed("d_negzero", 4'h1, 4'h9, 0, 0, 4'h8, 0);
        directed("d_0p25", 4'h1, 4'h1, 0, 0, 4'h0, 0);
        directed("d_4p5_rne", 4'h3, 4'h5, 0, 0, 4'h6, 0);
        directed("d_9_sat0", 4'h5, 4'h5, 0, 0, 4'h7, 1);
        directed("d_9_sat1", 4'h5, 4'h5, 1, 0, 4'h7, 0);
        directed("d_neg9", 4'hD, 4'h5, 0, 0, 4'hF, 1);
        directed("d_9_rtz", 4'h3, 4'h7, 0, 1, 4'h7, 1);

        // Golden wrong on lanes 0..2 for two beats.
        pulse_clr();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom);
            e = model_beat(a, b, '0, 0, 0);
            drive(a, b, e.res ^ 16'h0111, 0, 0);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("err_count_6", err_count, 6);
        check("err_count_w2_sat", err_count2, 3);

        // err_clr coinciding with a mismatching output transfer.
        @(posedge clk); #1;
        a = 16'($urandom); b = 16'($urandom);
        e = model_beat(a, b, '0, 0, 0);
        drive(a, b, e.res ^ 16'h0111, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check("clr_priority", err_count, 0);
        check("clr_priority_w2", err_count2, 0);

        // Random stream with random backpressure.
        sent = 0; cyc = 0;
        while (sent < 200 && cyc < 5000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || acc) begin
                if (sent < 200 && $urandom_range(0, 3) != 0) drive_random();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("stream_budget", cyc < 5000, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("stream_drained", q.size(), 0);

        // Fill both stages, then reset mid-flight.
        out_ready = 1'b0;
        @(posedge clk); #1 drive_random();
        @(posedge clk); #1 drive_random();
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err_count", err_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        directed("d_post_rst", 4'h3, 4'h3, 0, 0, 4'h4, 0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
